// File: rtl/icache_nway_pipe.sv
// N-way set-associative, 2-stage pipelined instruction cache with AXI-style line refill.
// Optional ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt outputs.
module icache_nway_pipe #(
  parameter int WAYS       = 2,
  parameter int INDEX_W    = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    valid_i,
  input  logic                    uncache_i,
  input  logic [31:0]             vaddr_i,
  input  logic [31:0]             paddr_i,
  output logic                    stall_o,
  output logic                    data_ok1,
  output logic                    data_ok2,
  output logic [31:0]             rdata1,
  output logic [31:0]             rdata2,
  output logic [31:0]             raddr1,
  output logic [31:0]             raddr2,
  output logic                    rd_req,
  input  logic                    rd_gnt,
  output logic [31:0]             rd_addr,
  output logic [7:0]              rd_len,
  input  logic                    ret_valid,
  input  logic [32*LINE_WORDS-1:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  localparam int SETS   = 1 << INDEX_W;
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int WORD_W = OFF_W - 2;
  localparam int TAG_W  = 32 - INDEX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [1:0] {S_RUN, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t state_reg, state_next;

  logic               s2_valid_reg;
  logic               s2_uncache_reg;
  logic [31:0]        s2_vaddr_reg;
  logic [31:0]        s2_paddr_reg;

  logic [INDEX_W-1:0] s2_index;
  logic [TAG_W-1:0]   s2_tag;
  logic [WORD_W-1:0]  s2_word;
  logic [INDEX_W-1:0] rd_index;

  logic [WAYS-1:0]    way_match;
  logic [WAYS-1:0]    way_vld;
  logic [LINE_W-1:0]  way_line [WAYS];

  logic [WAY_W-1:0]   victim_way;
  logic               victim_found;
  logic [WAY_W-1:0]   hit_way;
  logic               hit_found;
  logic               refill_we;

  logic [WAY_W-1:0]   rr_reg [SETS];

  logic               fwd_valid_reg;
  logic [WAY_W-1:0]   fwd_way_reg;
  logic [TAG_W-1:0]   fwd_tag_reg;
  logic [LINE_W-1:0]  fwd_line_reg;

  logic [LINE_W-1:0]  line_sel;
  logic [WORD_W-1:0]  sel_word;
  logic [WORD_W-1:0]  next_word;
  logic               cache_hit;

  assign s2_index = s2_paddr_reg[INDEX_W+OFF_W-1:OFF_W];
  assign s2_tag   = s2_paddr_reg[31:INDEX_W+OFF_W];
  assign s2_word  = s2_paddr_reg[OFF_W-1:2];
  assign rd_index = stall_o ? s2_index : paddr_i[INDEX_W+OFF_W-1:OFF_W];

  assign refill_we = ret_valid && !s2_uncache_reg &&
                     (state_reg == S_WAIT || state_reg == S_DRAIN);

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]  tag_mem [SETS];
      logic [LINE_W-1:0] data_mem [SETS];
      logic [TAG_W-1:0]  tag_q;
      logic [LINE_W-1:0] line_q;
      logic [SETS-1:0]   valid_reg;
      logic              fwd_sel;
      logic              way_we;

      assign way_we = refill_we && (victim_way == WAY_W'(gi));

      always_ff @(posedge clk) begin
        if (way_we) begin
          tag_mem[s2_index]  <= s2_tag;
          data_mem[s2_index] <= ret_data;
        end
        tag_q  <= tag_mem[rd_index];
        line_q <= data_mem[rd_index];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= '0;
        end else if (way_we) begin
          valid_reg[s2_index] <= 1'b1;
        end
      end

      // The array read launched in a refill cycle may be stale; take the line just written.
      assign fwd_sel       = fwd_valid_reg && (fwd_way_reg == WAY_W'(gi));
      assign way_line[gi]  = fwd_sel ? fwd_line_reg : line_q;
      assign way_vld[gi]   = valid_reg[s2_index];
      assign way_match[gi] = valid_reg[s2_index] &&
                             ((fwd_sel ? fwd_tag_reg : tag_q) == s2_tag);
    end
  endgenerate

  always_comb begin
    victim_way   = rr_reg[s2_index];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !way_vld[w]) begin
        victim_way   = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  always_comb begin
    hit_way   = '0;
    hit_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_found && way_match[w]) begin
        hit_way   = WAY_W'(w);
        hit_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    data_ok1   = 1'b0;
    rd_req     = 1'b0;
    cache_hit  = 1'b0;
    line_sel   = way_line[hit_way];
    case (state_reg)
      S_RUN: begin
        if (s2_valid_reg && !flush) begin
          if (!s2_uncache_reg && hit_found) begin
            data_ok1  = 1'b1;
            cache_hit = 1'b1;
          end else begin
            stall_o    = 1'b1;
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (flush) begin
          state_next = S_RUN;
        end else begin
          rd_req = 1'b1;
          if (rd_gnt) state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_o  = !ret_valid;
        line_sel = ret_data;
        if (ret_valid) begin
          state_next = S_RUN;
          data_ok1   = !flush;
        end else if (flush) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall_o = 1'b1;
        if (ret_valid) state_next = S_RUN;
      end
      default: state_next = S_RUN;
    endcase
  end

  // Uncached beats carry the word in lane 0 regardless of the address offset.
  assign sel_word  = s2_uncache_reg ? '0 : s2_word;
  assign next_word = sel_word + WORD_W'(1);
  assign data_ok2  = data_ok1 && !s2_uncache_reg && (s2_word != WORD_W'(LINE_WORDS - 1));

  assign rdata1 = data_ok1 ? line_sel[{sel_word, 5'b0} +: 32] : 32'h0;
  assign rdata2 = data_ok2 ? line_sel[{next_word, 5'b0} +: 32] : 32'h0;
  assign raddr1 = data_ok1 ? s2_vaddr_reg : 32'h0;
  assign raddr2 = data_ok2 ? s2_vaddr_reg + 32'd4 : 32'h0;

  assign rd_addr = !rd_req ? 32'h0 :
                   s2_uncache_reg ? s2_paddr_reg : {s2_paddr_reg[31:OFF_W], {OFF_W{1'b0}}};
  assign rd_len  = (rd_req && !s2_uncache_reg) ? 8'(LINE_WORDS - 1) : 8'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_RUN;
      s2_valid_reg   <= 1'b0;
      s2_uncache_reg <= 1'b0;
      s2_vaddr_reg   <= '0;
      s2_paddr_reg   <= '0;
      fwd_valid_reg  <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_reg[s] <= '0;
    end else begin
      state_reg     <= state_next;
      fwd_valid_reg <= refill_we && (rd_index == s2_index);
      if (!stall_o) begin
        s2_valid_reg   <= valid_i && !flush;
        s2_uncache_reg <= uncache_i;
        s2_vaddr_reg   <= vaddr_i;
        s2_paddr_reg   <= paddr_i;
      end else if (flush) begin
        s2_valid_reg <= 1'b0;
      end
      if (refill_we && !victim_found) begin
        rr_reg[s2_index] <= rr_reg[s2_index] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    fwd_way_reg  <= victim_way;
    fwd_tag_reg  <= s2_tag;
    fwd_line_reg <= ret_data;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (cache_hit) hit_cnt <= hit_cnt + 32'd1;
      if (state_reg == S_RUN && state_next == S_REQ && !s2_uncache_reg) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
